mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Parametrised multicycle integer multiply/divide engine feeding the HI/LO registers of the datapath.
//  Replaces the fixed 32-bit mult/div pair with one shared shift-add / restoring-division core.
//  Adds signed/unsigned mode, a start/busy/done handshake and a held div-by-zero flag.
//  The control unit pulses start, waits for done, then writes hi/lo into HI/LO.
// PARAMETERS
//  WIDTH   32   operand width; even, >= 4; hi/lo are WIDTH bits each
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  start      in   1      request; sampled only in IDLE or DONE
//  op         in   1      0 = multiply, 1 = divide; sampled with start
//  is_signed  in   1      1 = two's-complement operands; sampled with start
//  a          in   WIDTH  multiplicand / dividend; sampled with start
//  b          in   WIDTH  multiplier / divisor; sampled with start
//  busy       out  1      high in RUN and FIX
//  done       out  1      one-cycle pulse; hi/lo/div0 valid from this cycle
//  hi         out  WIDTH  mult: product[2W-1:W]; div: remainder
//  lo         out  WIDTH  mult: product[W-1:0]; div: quotient
//  div0       out  1      divide with b == 0; held until next accepted start
// BEHAVIOUR
//  - Reset (reset = 0, any state): state = IDLE; hi, lo = 0; busy, done, div0 = 0.
//    Reset mid-operation abandons the operation, and no done is produced.
//  - FSM: IDLE -start-> RUN -> FIX -> DONE -> IDLE. DONE accepts start exactly like IDLE.
//  - Accept edge E0 latches op and is_signed.
//    Signed mode: latches |a| and |b| plus the result sign bits.
//    Unsigned mode: latches the raw operands.
//    Iteration counter is cleared; div0 is cleared.
//  - RUN: one radix-2 step per edge, WIDTH edges.
//    Mult: shift-add on a 2*WIDTH accumulator.
//    Div: restoring division; the remainder register is WIDTH+1 bits.
//  - FIX: one edge. Negates the result if the sign bits require it, registers hi/lo, enters DONE.
//    Mult: 2W product negated when sign(a) != sign(b).
//    Div: quotient negated when sign(a) != sign(b); remainder takes the sign of a.
//    Quotient truncates toward zero.
//  - Latency: done is high in the cycle after edge E0 + WIDTH + 1. busy is high from E0 up to that cycle.
//  - Divide-by-zero: op = 1 and b == 0 at acceptance -> go straight to DONE.
//    done is high after E0 + 1, div0 = 1, busy stays 0, hi/lo keep their previous values.
//  - Overflow case MIN / -1 (signed): lo = MIN (wraps), hi = 0, no flag.
//  - start while busy: ignored, no queuing. Operand changes while busy have no effect.
//  - hi/lo change only at the FIX edge. They are stable between operations.
//  - Counter width is $clog2(WIDTH+1). All arithmetic is unsigned on magnitudes. No `signed` nets.
// CONFIGURATION
//  EARLY_TERM_EN  defined:
//    Multiply leaves RUN when the remaining shifted multiplier is zero (after >= 1 step).
//    k = max(1, index of highest set bit of |b| + 1).
//    done appears after E0 + k + 1. Results are identical.
//    Divide is unaffected.
//  EARLY_TERM_EN  undefined: every operation uses the fixed WIDTH + 1 latency above.
// TESTING (WIDTH = 32)
//  1. Unsigned mult 0xFFFFFFFF * 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
//     done after E0 + 33; busy high for exactly 33 cycles.
//  2. Signed mult -3 * 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
//     Unsigned mult of the same bits -> hi = 0x00000004, lo = 0xFFFFFFF1.
//  3. Signed div -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
//     Signed div 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
//     Unsigned div 100 / 7 -> lo = 14, hi = 2.
//  4. Div 5 / 0 with hi/lo = 0x11/0x22 -> done after E0 + 1, div0 = 1, hi/lo stay 0x11/0x22.
//     Next accepted start clears div0.
//  5. start pulsed mid-RUN with different operands -> ignored, first result delivered, one done.
//     reset low mid-RUN -> outputs 0 immediately (async), no done.
//     start in the DONE cycle -> accepted back-to-back.
//  6. EARLY_TERM_EN: mult 1000 * 3 -> lo = 3000, hi = 0, done after E0 + 3.
//     Without the macro: same result, done after E0 + 33.

Source files
------------

// File: rtl/mult_div_unit.sv
// Shared multicycle multiply (shift-add) / divide (restoring) engine feeding HI/LO; define EARLY_TERM_EN for multiply early exit.
// done follows the accept edge by WIDTH+1 edges (div-by-zero: 1 edge); start is ignored while busy, nothing is queued.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_FIX  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ZERO = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             op_q, op_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             div0_q, div0_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             accept;
  logic             a_neg, b_neg;
  logic             run_last;
  logic             div_ok;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [W2-1:0]    mul_sum, prod_fix;
  logic [WIDTH+1:0] div_diff;

  assign a_neg  = is_signed & a[WIDTH-1];
  assign b_neg  = is_signed & b[WIDTH-1];
  assign a_mag  = a_neg ? (~a + WIDTH'(1)) : a;
  assign b_mag  = b_neg ? (~b + WIDTH'(1)) : b;
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // x_q holds the left-shifting multiplicand (mult) or the divisor in its low half (div);
  // y_q holds the right-shifting multiplier (mult) or dividend bits turning into quotient bits (div).
  assign mul_sum  = acc_q + (y_q[0] ? x_q : '0);
  assign div_diff = {rem_q, y_q[WIDTH-1]} - {2'b00, x_q[WIDTH-1:0]};
  assign div_ok   = ~div_diff[WIDTH+1];

`ifdef EARLY_TERM_EN
  assign run_last = (cnt_q == LAST) || (!op_q && (y_q[WIDTH-1:1] == '0));
`else
  assign run_last = (cnt_q == LAST);
`endif

  assign prod_fix = neg_q  ? (~acc_q + W2'(1)) : acc_q;
  assign quo_fix  = neg_q  ? (~y_q + WIDTH'(1)) : y_q;
  assign rem_fix  = rneg_q ? (~rem_q[WIDTH-1:0] + WIDTH'(1)) : rem_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          op_d   = op;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = '0;
          acc_d  = '0;
          rem_d  = '0;
          x_d    = {{WIDTH{1'b0}}, (op ? b_mag : a_mag)};
          y_d    = op ? a_mag : b_mag;
          div0_d = op && (b == '0);
          state_d = (op && (b == '0)) ? S_ZERO : S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q) begin
          rem_d = div_ok ? div_diff[WIDTH:0] : {rem_q[WIDTH-1:0], y_q[WIDTH-1]};
          y_d   = {y_q[WIDTH-2:0], div_ok};
        end else begin
          acc_d = mul_sum;
          x_d   = x_q << 1;
          y_d   = y_q >> 1;
        end
        if (run_last) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (op_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_DONE;
      end
      // Divide-by-zero spends one idle edge so done keeps its one-edge offset; busy stays low.
      S_ZERO: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN) || (state_q == S_FIX);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors, corner cases and randomized ops vs. an arithmetic reference.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic         op;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div0;

  int checks;
  int errors;
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .div0      (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit integer arithmetic; SV division truncates toward zero.
  function automatic void ref_op(input logic o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                 inout logic [W-1:0] rh, inout logic [W-1:0] rl, output logic rz);
    longint sx, sy;
    logic [63:0] p, q, r;
    sx = s ? longint'($signed(x)) : longint'({32'b0, x});
    sy = s ? longint'($signed(y)) : longint'({32'b0, y});
    rz = 1'b0;
    if (!o) begin
      p  = 64'(sx * sy);
      rh = p[63:32];
      rl = p[31:0];
    end else if (y == 0) begin
      rz = 1'b1;
    end else begin
      q  = 64'(sx / sy);
      r  = 64'(sx % sy);
      rh = r[31:0];
      rl = q[31:0];
    end
  endfunction

  function automatic int exp_lat(input logic o, input logic s, input logic [W-1:0] y);
    if (o && (y == 0)) return 1;
`ifdef EARLY_TERM_EN
    if (!o) begin
      logic [W-1:0] m;
      int k;
      m = (s && y[W-1]) ? -y : y;
      k = 1;
      for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
      return k + 1;
    end
`endif
    return W + 1;
  endfunction

  // Issues one request and waits for done; lat = edges after the accept edge until done is seen.
  task automatic run_op(input logic o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output int bcnt, output logic [W-1:0] h0, output logic [W-1:0] l0,
                        output logic z0);
    @(negedge clk);
    start = 1'b1; op = o; is_signed = s; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1; bcnt = 0; h0 = hi; l0 = lo; z0 = div0;
    for (int n = 0; n <= W + 8; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy) bcnt++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; op = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (hi !== '0)   begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    checks++; if (lo !== '0)   begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL reset_div0 got %b exp 0", div0); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL idle_after_reset got %b exp 00", {busy, done}); end
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_directed;
    logic         vo[7]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic         vs[7]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] va[7]   = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'h80000000, 32'd100, 32'd1000};
    logic [W-1:0] vb[7]   = '{32'hFFFFFFFF, 32'd5, 32'd5, 32'd2, 32'hFFFFFFFF, 32'd7, 32'd3};
    logic [W-1:0] vhi[7]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000004, 32'hFFFFFFFF, 32'h0, 32'd2, 32'd0};
    logic [W-1:0] vlo[7]  = '{32'h00000001, 32'hFFFFFFF1, 32'hFFFFFFF1, 32'hFFFFFFFD, 32'h80000000, 32'd14, 32'd3000};
    int lat, bcnt, el;
    logic [W-1:0] h0, l0;
    logic z0;
    for (int i = 0; i < 7; i++) begin
      el = exp_lat(vo[i], vs[i], vb[i]);
      run_op(vo[i], vs[i], va[i], vb[i], lat, bcnt, h0, l0, z0);
      checks++; if (lat != el)  begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, el); end
      checks++; if (bcnt != el) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d exp %0d", i, bcnt, el); end
      checks++; if ({h0, l0} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL dir%0d_hold got %h_%h exp %h_%h", i, h0, l0, exp_hi, exp_lo); end
      checks++; if (hi !== vhi[i]) begin errors++; $display("FAIL dir%0d_hi got %h exp %h", i, hi, vhi[i]); end
      checks++; if (lo !== vlo[i]) begin errors++; $display("FAIL dir%0d_lo got %h exp %h", i, lo, vlo[i]); end
      checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL dir%0d_div0 got %b exp 0", i, div0); end
      exp_hi = vhi[i]; exp_lo = vlo[i];
    end
  endtask

  task automatic test_div0;
    int lat, bcnt;
    logic [W-1:0] h0, l0;
    logic z0;
    run_op(1'b1, 1'b0, 32'h2211, 32'h100, lat, bcnt, h0, l0, z0);
    checks++; if ({hi, lo} !== {32'h11, 32'h22}) begin errors++; $display("FAIL div0_setup got %h_%h exp 00000011_00000022", hi, lo); end
    run_op(1'b1, 1'b1, 32'd5, 32'd0, lat, bcnt, h0, l0, z0);
    checks++; if (lat != 1)  begin errors++; $display("FAIL div0_latency got %0d exp 1", lat); end
    checks++; if (bcnt != 0) begin errors++; $display("FAIL div0_busy got %0d exp 0", bcnt); end
    checks++; if (div0 !== 1'b1) begin errors++; $display("FAIL div0_flag got %b exp 1", div0); end
    checks++; if ({hi, lo} !== {32'h11, 32'h22}) begin errors++; $display("FAIL div0_keep got %h_%h exp 00000011_00000022", hi, lo); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({div0, done} !== 2'b10) begin errors++; $display("FAIL div0_held got %b exp 10", {div0, done}); end
    run_op(1'b0, 1'b0, 32'd6, 32'd7, lat, bcnt, h0, l0, z0);
    checks++; if (z0 !== 1'b0) begin errors++; $display("FAIL div0_clear got %b exp 0", z0); end
    checks++; if ({hi, lo} !== {32'd0, 32'd42}) begin errors++; $display("FAIL div0_next got %h_%h exp 0_2a", hi, lo); end
    exp_hi = 32'd0; exp_lo = 32'd42;
  endtask

  task automatic test_ignore_start;
    int lat, dcnt, el;
    logic [W-1:0] rh, rl;
    logic rz;
    rh = exp_hi; rl = exp_lo;
    ref_op(1'b0, 1'b0, 32'h1234, 32'h5678, rh, rl, rz);
    el = exp_lat(1'b0, 1'b0, 32'h5678);
    @(negedge clk);
    start = 1'b1; op = 1'b0; is_signed = 1'b0; a = 32'h1234; b = 32'h5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1; dcnt = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dcnt++;
        if (lat < 0) lat = n;
      end
      if (n == 5) begin
        start = 1'b1; op = 1'b1; is_signed = 1'b1; a = 32'd77; b = 32'd3;
      end
      if (n == 6) start = 1'b0;
    end
    checks++; if (dcnt != 1) begin errors++; $display("FAIL ign_done_count got %0d exp 1", dcnt); end
    checks++; if (lat != el) begin errors++; $display("FAIL ign_latency got %0d exp %0d", lat, el); end
    checks++; if ({hi, lo} !== {rh, rl}) begin errors++; $display("FAIL ign_result got %h_%h exp %h_%h", hi, lo, rh, rl); end
    exp_hi = rh; exp_lo = rl;
  endtask

  task automatic test_back_to_back;
    int lat, bcnt, el;
    logic [W-1:0] h0, l0, rh, rl;
    logic z0, rz;
    rh = exp_hi; rl = exp_lo;
    ref_op(1'b1, 1'b1, 32'hFFFFFF9C, 32'd9, rh, rl, rz);
    run_op(1'b1, 1'b1, 32'hFFFFFF9C, 32'd9, lat, bcnt, h0, l0, z0);
    checks++; if ({hi, lo} !== {rh, rl}) begin errors++; $display("FAIL b2b_first got %h_%h exp %h_%h", hi, lo, rh, rl); end
    exp_hi = rh; exp_lo = rl;
    ref_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, rh, rl, rz);
    el = exp_lat(1'b0, 1'b1, 32'hFFFFFFFF);
    run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bcnt, h0, l0, z0);
    checks++; if (lat != el) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", lat, el); end
    checks++; if ({h0, l0} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL b2b_hold got %h_%h exp %h_%h", h0, l0, exp_hi, exp_lo); end
    checks++; if ({hi, lo} !== {rh, rl}) begin errors++; $display("FAIL b2b_second got %h_%h exp %h_%h", hi, lo, rh, rl); end
    exp_hi = rh; exp_lo = rl;
  endtask

  task automatic test_reset_mid;
    int dcnt;
    @(negedge clk);
    start = 1'b1; op = 1'b1; is_signed = 1'b0; a = 32'd1000; b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++; if ({hi, lo} !== '0) begin errors++; $display("FAIL rst_mid_hilo got %h_%h exp 0_0", hi, lo); end
    checks++; if ({busy, done, div0} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags got %b exp 000", {busy, done, div0}); end
    @(negedge clk);
    reset = 1'b1;
    dcnt = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) dcnt++;
    end
    checks++; if (dcnt != 0) begin errors++; $display("FAIL rst_mid_no_done got %0d exp 0", dcnt); end
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_random;
    int lat, bcnt, el, eb, sel;
    logic o, s, z0, rz;
    logic [W-1:0] x, y, h0, l0, rh, rl;
    for (int i = 0; i < 40; i++) begin
      o = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      sel = $urandom_range(0, 7);
      y = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(0, 15)) : (sel == 2) ? 32'hFFFFFFFF : $urandom;
      if ($urandom_range(0, 9) == 0) x = 32'h80000000;
      rh = exp_hi; rl = exp_lo;
      ref_op(o, s, x, y, rh, rl, rz);
      el = exp_lat(o, s, y);
      eb = rz ? 0 : el;
      run_op(o, s, x, y, lat, bcnt, h0, l0, z0);
      checks++; if (lat != el)  begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, el); end
      checks++; if (bcnt != eb) begin errors++; $display("FAIL rnd%0d_busy got %0d exp %0d", i, bcnt, eb); end
      checks++; if ({h0, l0} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL rnd%0d_hold got %h_%h exp %h_%h", i, h0, l0, exp_hi, exp_lo); end
      checks++; if (hi !== rh) begin errors++; $display("FAIL rnd%0d_hi op=%b s=%b a=%h b=%h got %h exp %h", i, o, s, x, y, hi, rh); end
      checks++; if (lo !== rl) begin errors++; $display("FAIL rnd%0d_lo op=%b s=%b a=%h b=%h got %h exp %h", i, o, s, x, y, lo, rl); end
      checks++; if (div0 !== rz) begin errors++; $display("FAIL rnd%0d_div0 got %b exp %b", i, div0, rz); end
      exp_hi = rh; exp_lo = rl;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_div0();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
